// File: rtl/la_capture_ctrl.sv
// Logic-analyzer capture sequencer: owns the single-port sample RAM, fills it
// around a trigger, then hands the address bus to the VGA display reader.
module la_capture_ctrl #(
    parameter int CH         = 8,
    parameter int DEPTH_BITS = 10,
    parameter int PRE_TRIG   = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic [CH-1:0]         sample_in,
    input  logic [CH-1:0]         trig_mask,
    input  logic [CH-1:0]         trig_value,
    input  logic [7:0]            rate_div,
    input  logic                  video_on,
    input  logic [11:0]           pixel_x,
    output logic [DEPTH_BITS-1:0] ram_addr,
    output logic                  ram_we,
    output logic [CH-1:0]         ram_wdata,
    output logic                  disp_valid,
    output logic [2:0]            state,
    output logic [DEPTH_BITS-1:0] trig_addr,
    output logic                  done
);

    localparam int DEPTH  = 1 << DEPTH_BITS;
    localparam int POST_N = DEPTH - PRE_TRIG - 1;
    localparam logic [DEPTH_BITS-1:0] PRE_LAST  = DEPTH_BITS'(PRE_TRIG - 1);
    localparam logic [DEPTH_BITS-1:0] POST_LAST = DEPTH_BITS'(POST_N - 1);
    localparam logic [DEPTH_BITS-1:0] PRE_OFS   = DEPTH_BITS'(PRE_TRIG);
    localparam logic [12:0]           DEPTH_U   = 13'(DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE       = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t                st;
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] pre_cnt;
    logic [DEPTH_BITS-1:0] post_cnt;
    logic [7:0]            div_cnt;
    logic                  tick;
    logic                  active;
    logic [DEPTH_BITS-1:0] start_addr;

    function automatic logic trig_hit(input logic [CH-1:0] s,
                                      input logic [CH-1:0] v,
                                      input logic [CH-1:0] m);
        return ((s ^ v) & m) == '0;
    endfunction

    assign state      = st;
    assign active     = (st == PRE) || (st == WAIT_TRIG) || (st == POST);
    assign tick       = (div_cnt == rate_div);
    assign start_addr = trig_addr - PRE_OFS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            disp_valid <= 1'b0;
            trig_addr  <= '0;
            done       <= 1'b0;
            wr_ptr     <= '0;
            div_cnt    <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
        end else begin
            ram_we     <= 1'b0;
            disp_valid <= 1'b0;
            if (arm) begin
                wr_ptr   <= '0;
                div_cnt  <= '0;
                pre_cnt  <= '0;
                post_cnt <= '0;
                done     <= 1'b0;
                st       <= (PRE_TRIG == 0) ? WAIT_TRIG : PRE;
            end else begin
                if (active)
                    div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
                else
                    div_cnt <= 8'd0;

                if (active && tick) begin
                    ram_we    <= 1'b1;
                    ram_addr  <= wr_ptr;
                    ram_wdata <= sample_in;
                    wr_ptr    <= wr_ptr + DEPTH_BITS'(1);
                end

                case (st)
                    PRE: begin
                        if (tick) begin
                            pre_cnt <= pre_cnt + DEPTH_BITS'(1);
                            if (pre_cnt == PRE_LAST)
                                st <= WAIT_TRIG;
                        end
                    end
                    WAIT_TRIG: begin
                        if (tick && trig_hit(sample_in, trig_value, trig_mask)) begin
                            trig_addr <= wr_ptr;
                            post_cnt  <= '0;
                            if (POST_N == 0) begin
                                st   <= DONE;
                                done <= 1'b1;
                            end else begin
                                st <= POST;
                            end
                        end
                    end
                    POST: begin
                        if (tick) begin
                            post_cnt <= post_cnt + DEPTH_BITS'(1);
                            if (post_cnt == POST_LAST) begin
                                st   <= DONE;
                                done <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        // Display reads window the ring so column 0 is the oldest kept sample.
                        ram_addr   <= start_addr + pixel_x[DEPTH_BITS-1:0];
                        disp_valid <= video_on && ({1'b0, pixel_x} < DEPTH_U);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Self-checking bench for la_capture_ctrl: directed scenarios plus randomized
// captures, compared against a write-count based model and a RAM window check.
module tb_la_capture_ctrl;

    localparam int CH     = 8;
    localparam int DB     = 4;
    localparam int PRE    = 4;
    localparam int DEPTH  = 16;
    localparam int POST_N = DEPTH - PRE - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm = 1'b0;
    logic [CH-1:0] sample_in = '0;
    logic [CH-1:0] trig_mask = '0;
    logic [CH-1:0] trig_value = '0;
    logic [7:0]    rate_div = '0;
    logic          video_on = 1'b0;
    logic [11:0]   pixel_x = '0;
    logic [DB-1:0] ram_addr;
    logic          ram_we;
    logic [CH-1:0] ram_wdata;
    logic          disp_valid;
    logic [2:0]    state;
    logic [DB-1:0] trig_addr;
    logic          done;

    la_capture_ctrl #(.CH(CH), .DEPTH_BITS(DB), .PRE_TRIG(PRE)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .sample_in(sample_in),
        .trig_mask(trig_mask), .trig_value(trig_value), .rate_div(rate_div),
        .video_on(video_on), .pixel_x(pixel_x), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .disp_valid(disp_valid),
        .state(state), .trig_addr(trig_addr), .done(done)
    );

    always #5 clk = ~clk;

    logic [CH-1:0] mem [DEPTH];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: capture progress tracked as counts of writes since arm.
    bit            m_armed, m_trig, m_done;
    int            n_wr, n_post, m_div, win_px;
    logic [DB-1:0] m_taddr, e_addr;
    logic [CH-1:0] e_wdata;
    bit            e_we, e_dv;
    logic [CH-1:0] hist[$];

    function automatic logic [2:0] m_state();
        if (!m_armed)       return 3'd0;
        if (m_done)         return 3'd4;
        if (m_trig)         return 3'd3;
        if (n_wr < PRE)     return 3'd1;
        return 3'd2;
    endfunction

    task automatic model_reset();
        m_armed = 0; m_trig = 0; m_done = 0;
        n_wr = 0; n_post = 0; m_div = 0; win_px = 0;
        m_taddr = '0; e_addr = '0; e_wdata = '0; e_we = 0; e_dv = 0;
        hist.delete();
    endtask

    task automatic model_update();
        bit t;
        e_we = 0; e_dv = 0;
        if (arm) begin
            m_armed = 1; m_trig = 0; m_done = 0;
            n_wr = 0; n_post = 0; m_div = 0;
            hist.delete();
        end else if (m_armed && !m_done) begin
            t = (m_div == int'(rate_div));
            m_div = t ? 0 : m_div + 1;
            if (t) begin
                e_we = 1;
                e_addr = DB'(n_wr);
                e_wdata = sample_in;
                hist.push_back(sample_in);
                if (n_wr >= PRE) begin
                    if (!m_trig) begin
                        if (((sample_in ^ trig_value) & trig_mask) == 0) begin
                            m_trig = 1;
                            m_taddr = DB'(n_wr);
                            if (POST_N == 0) m_done = 1;
                        end
                    end else begin
                        n_post++;
                        if (n_post == POST_N) m_done = 1;
                    end
                end
                n_wr++;
            end
        end else if (m_done) begin
            e_addr = DB'(int'(m_taddr) - PRE + int'(pixel_x[DB-1:0]));
            e_dv   = video_on && (pixel_x < 12'(DEPTH));
            win_px = int'(pixel_x[DB-1:0]);
        end
    endtask

    task automatic compare();
        check("state", state, m_state());
        check("done", done, m_done);
        check("ram_we", ram_we, e_we);
        check("ram_addr", ram_addr, e_addr);
        check("ram_wdata", ram_wdata, e_wdata);
        check("disp_valid", disp_valid, e_dv);
        check("trig_addr", trig_addr, m_taddr);
        if (e_dv && hist.size() >= DEPTH)
            check("disp_data", mem[ram_addr], hist[hist.size() - DEPTH + win_px]);
    endtask

    int  sidx = 0;
    bit  directed = 1;

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
        sidx = 0;
    endtask

    task automatic run_until(input logic [2:0] target, input int max_cyc,
                             output int cyc, output int wr);
        cyc = 0; wr = 0;
        while (state != target && cyc < max_cyc) begin
            sample_in = directed ? ((sidx == 6) ? 8'hA5 : 8'(sidx)) : 8'($urandom);
            step();
            sidx++;
            cyc++;
            if (ram_we) wr++;
        end
        if (state != target) check("timeout", state, target);
    endtask

    int cyc, wr;

    initial begin
        model_reset();
        #2;
        compare();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted mid-capture clears everything without a clock edge.
        trig_mask = 8'h00;
        do_arm();
        run_until(3'd3, 40, cyc, wr);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_state", state, 3'd0);
        check("rst_we", ram_we, 1'b0);
        compare();
        #1;
        rst_n = 1'b1;

        // Basic capture with trigger on the 7th sample.
        trig_mask = 8'hFF; trig_value = 8'hA5; rate_div = 8'd0;
        do_arm();
        run_until(3'd4, 60, cyc, wr);
        check("basic_writes", wr, 18);
        check("basic_cycles", cyc, 18);
        check("basic_trig_addr", trig_addr, 6);

        video_on = 1'b1; pixel_x = 12'd0;  step();
        check("disp_x0_addr", ram_addr, 2);
        check("disp_x0_valid", disp_valid, 1);
        pixel_x = 12'd15; step();
        check("disp_x15_addr", ram_addr, 1);
        pixel_x = 12'd20; step();
        check("disp_x20_valid", disp_valid, 0);
        pixel_x = 12'd3; video_on = 1'b0; step();
        check("disp_voff_valid", disp_valid, 0);
        video_on = 1'b1;

        // Zero mask triggers on the first WAIT_TRIG tick.
        trig_mask = 8'h00;
        do_arm();
        run_until(3'd4, 60, cyc, wr);
        check("mask0_trig_addr", trig_addr, 4);

        // Prescaler: one write every rate_div+1 clocks.
        rate_div = 8'd3;
        do_arm();
        run_until(3'd4, 200, cyc, wr);
        check("presc_cycles", cyc, 64);
        check("presc_writes", wr, 16);
        rate_div = 8'd0;

        // Re-arm during POST, then during DONE.
        do_arm();
        run_until(3'd3, 40, cyc, wr);
        do_arm();
        check("rearm_post_state", state, 3'd1);
        check("rearm_post_done", done, 0);
        run_until(3'd4, 60, cyc, wr);
        do_arm();
        check("rearm_done_state", state, 3'd1);
        check("rearm_done_done", done, 0);
        step();
        check("rearm_first_addr", ram_addr, 0);
        check("rearm_first_we", ram_we, 1);

        // Randomized captures with occasional re-arm and random display scan.
        directed = 0;
        for (int it = 0; it < 30; it++) begin
            int done_cyc;
            rate_div   = 8'($urandom_range(0, 3));
            trig_mask  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
            trig_value = 8'($urandom);
            do_arm();
            done_cyc = 0;
            for (int c = 0; c < 300 && done_cyc < 24; c++) begin
                sample_in = 8'($urandom);
                pixel_x   = 12'($urandom_range(0, 23));
                video_on  = ($urandom_range(0, 3) != 0);
                arm       = ($urandom_range(0, 149) == 0);
                step();
                arm = 1'b0;
                if (state == 3'd4) done_cyc++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
